// File: rtl/idelay_seq_pkg.sv
// Shared types and default constants for the IDELAYCTRL calibration / tap-adjust sequencer.
package idelay_seq_pkg;

   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_WAIT   = 3'd1,
      S_RUN    = 3'd2,
      S_PULSE  = 3'd3,
      S_SETTLE = 3'd4
   } state_t;

   localparam int DEF_NUM_CH        = 4;
   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_RDY_TIMEOUT   = 4096;
   localparam int DEF_SETTLE_CYCLES = 4;
   localparam int DEF_CNT_W         = 8;

   // States in which calibration is considered valid.
   function automatic logic is_active(input state_t s);
      return (s == S_RUN) || (s == S_PULSE) || (s == S_SETTLE);
   endfunction

endpackage

// File: rtl/idelay_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, search pointer advanced on accepted grants.
module idelay_rr_arb
   import idelay_seq_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] req_i,
   input  logic              advance_i,
   output logic [NUM_CH-1:0] gnt_o
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SW    = PTR_W + 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] gnt_idx;
   logic [PTR_W-1:0] idx;
   logic [SW-1:0]    sum;
   logic             found;

   always_comb begin
      gnt_o   = '0;
      found   = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      sum     = '0;
      for (int off = 0; off < NUM_CH; off++) begin
         sum = {1'b0, ptr_q} + SW'(off);
         if (sum >= SW'(NUM_CH)) begin
            sum = sum - SW'(NUM_CH);
         end
         idx = sum[PTR_W-1:0];
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx    = idx;
         end
      end
   end

   // Next search starts one past the channel just granted.
   always_comb begin
      ptr_d = ptr_q;
      if (advance_i && found) begin
         ptr_d = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/idelay_ctrl_sequencer.sv
// Calibrates IDELAYCTRL (reset pulse, wait for RDY, retry/relock) and then
// time-shares the IDELAY CE/INC path between requesters.
module idelay_ctrl_sequencer
   import idelay_seq_pkg::*;
#(
   parameter int NUM_CH        = DEF_NUM_CH,
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int RDY_TIMEOUT   = DEF_RDY_TIMEOUT,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              dlyctrl_rdy_i,
   output logic              dlyctrl_rst_o,
   output logic              ready_o,
   output logic [CNT_W-1:0]  relock_cnt_o,
   input  logic [NUM_CH-1:0] req_i,
   input  logic [NUM_CH-1:0] req_inc_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [NUM_CH-1:0] dly_ce_o,
   output logic [NUM_CH-1:0] dly_inc_o,
   output logic [NUM_CH-1:0] ack_o
);

   localparam int TMR_MAX0 = (RST_CYCLES > RDY_TIMEOUT) ? RST_CYCLES : RDY_TIMEOUT;
   localparam int TMR_MAX  = (TMR_MAX0 > SETTLE_CYCLES) ? TMR_MAX0 : SETTLE_CYCLES;
   localparam int TMR_W    = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] WAIT_LAST   = TMR_W'(RDY_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

   state_t            state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [CNT_W-1:0]  relock_q, relock_d;
   logic [NUM_CH-1:0] sel_q, sel_d;
   logic              rdy_meta_q, rdy_s_q;
   logic              lose;
   logic              arb_adv;
   logic [NUM_CH-1:0] arb_gnt;

   logic              dlyctrl_rst_q, ready_q;
   logic [NUM_CH-1:0] gnt_q, dly_ce_q, dly_inc_q, ack_q;

   idelay_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .advance_i (arb_adv),
      .gnt_o     (arb_gnt)
   );

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      sel_d   = sel_q;
      lose    = 1'b0;
      arb_adv = 1'b0;
      case (state_q)
         S_RST: begin
            if (tmr_q == RST_LAST) begin
               state_d = S_WAIT;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (rdy_s_q) begin
               state_d = S_RUN;
               tmr_d   = '0;
            end else if (tmr_q == WAIT_LAST) begin
               lose = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_RUN: begin
            // A lock loss outranks a simultaneous request.
            if (!rdy_s_q) begin
               lose = 1'b1;
            end else if (|req_i) begin
               state_d = S_PULSE;
               sel_d   = arb_gnt;
               arb_adv = 1'b1;
            end
         end
         S_PULSE: begin
            if (!rdy_s_q) begin
               lose = 1'b1;
            end else begin
               state_d = S_SETTLE;
               tmr_d   = '0;
            end
         end
         S_SETTLE: begin
            if (!rdy_s_q) begin
               lose = 1'b1;
            end else if (tmr_q == SETTLE_LAST) begin
               state_d = S_RUN;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            lose = 1'b1;
         end
      endcase
      if (lose) begin
         state_d = S_RST;
         tmr_d   = '0;
      end
      relock_d = (lose && !(&relock_q)) ? relock_q + 1'b1 : relock_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdy_meta_q    <= 1'b0;
         rdy_s_q       <= 1'b0;
         state_q       <= S_RST;
         tmr_q         <= '0;
         relock_q      <= '0;
         sel_q         <= '0;
         dlyctrl_rst_q <= 1'b1;
         ready_q       <= 1'b0;
         gnt_q         <= '0;
         dly_ce_q      <= '0;
         dly_inc_q     <= '0;
         ack_q         <= '0;
      end else begin
         rdy_meta_q    <= dlyctrl_rdy_i;
         rdy_s_q       <= rdy_meta_q;
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         relock_q      <= relock_d;
         sel_q         <= sel_d;
         // Outputs registered from next-state so they line up with the state they describe.
         dlyctrl_rst_q <= (state_d == S_RST);
         ready_q       <= is_active(state_d);
         gnt_q         <= ((state_d == S_PULSE) || (state_d == S_SETTLE)) ? sel_d : '0;
         dly_ce_q      <= (state_d == S_PULSE) ? sel_d : '0;
         dly_inc_q     <= (state_d == S_PULSE) ? (sel_d & req_inc_i) : '0;
         ack_q         <= ((state_d == S_SETTLE) && (tmr_d == SETTLE_LAST)) ? sel_d : '0;
      end
   end

   assign dlyctrl_rst_o = dlyctrl_rst_q;
   assign ready_o       = ready_q;
   assign relock_cnt_o  = relock_q;
   assign gnt_o         = gnt_q;
   assign dly_ce_o      = dly_ce_q;
   assign dly_inc_o     = dly_inc_q;
   assign ack_o         = ack_q;

endmodule

// File: tb/tb_idelay_ctrl_sequencer.sv
// Directed bench for idelay_ctrl_sequencer: calibration, timeout, round-robin, lock loss, saturation.
module tb_idelay_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rdy = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] req_inc = 4'b0000;
   logic       dlyctrl_rst;
   logic       ready;
   logic [7:0] relock;
   logic [3:0] gnt;
   logic [3:0] dly_ce;
   logic [3:0] dly_inc;
   logic [3:0] ack;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   idelay_ctrl_sequencer #(
      .NUM_CH(4), .RST_CYCLES(16), .RDY_TIMEOUT(4096), .SETTLE_CYCLES(4), .CNT_W(8)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .dlyctrl_rdy_i (rdy),
      .dlyctrl_rst_o (dlyctrl_rst),
      .ready_o       (ready),
      .relock_cnt_o  (relock),
      .req_i         (req),
      .req_inc_i     (req_inc),
      .gnt_o         (gnt),
      .dly_ce_o      (dly_ce),
      .dly_inc_o     (dly_inc),
      .ack_o         (ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Counts consecutive sampled cycles with dlyctrl_rst at the given level.
   task automatic measure(input logic level, input int limit, output int n);
      n = 0;
      while ((dlyctrl_rst === level) && (n < limit)) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_ce(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while ((dly_ce === 4'b0000) && (n < limit));
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b0; req = 4'b0000; req_inc = 4'b0000;
      repeat (5) tick();
      tests++; if (dlyctrl_rst !== 1'b1) begin fails++; $display("FAIL reset_dlyctrl_rst got=%b exp=1", dlyctrl_rst); end
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", ready); end
      tests++; if (relock !== 8'd0) begin fails++; $display("FAIL reset_relock got=%0d exp=0", relock); end
      tests++; if ({gnt, dly_ce, dly_inc, ack} !== 16'h0000) begin
         fails++; $display("FAIL reset_chan_outputs got=%h exp=0000", {gnt, dly_ce, dly_inc, ack});
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_timeout();
      int n;
      rst = 1'b0;
      measure(1'b1, 100, n);
      tests++; if (n !== 16) begin fails++; $display("FAIL timeout_first_rst_width got=%0d exp=16", n); end
      measure(1'b0, 5000, n);
      tests++; if (n !== 4096) begin fails++; $display("FAIL timeout_wait_len got=%0d exp=4096", n); end
      tests++; if (relock !== 8'd1) begin fails++; $display("FAIL timeout_relock got=%0d exp=1", relock); end
      measure(1'b1, 100, n);
      tests++; if (n !== 16) begin fails++; $display("FAIL timeout_repulse_width got=%0d exp=16", n); end
      $display("[TB] test_timeout done");
   endtask

   task automatic test_calibrate();
      int n;
      rst = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
      measure(1'b1, 100, n);
      tests++; if (n !== 16) begin fails++; $display("FAIL cal_rst_width got=%0d exp=16", n); end
      repeat (10) tick();
      rdy = 1'b1;
      repeat (2) tick();
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL cal_ready_early got=%b exp=0", ready); end
      tick();
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL cal_ready_latency got=%b exp=1", ready); end
      tests++; if (relock !== 8'd0) begin fails++; $display("FAIL cal_relock got=%0d exp=0", relock); end
      $display("[TB] test_calibrate done");
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ce  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] exp_inc [5] = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
      int n;
      int last;
      last = 0;
      req_inc = 4'b0101;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ce(20, n);
         if (k == 0) begin
            tests++; if (n !== 1) begin fails++; $display("FAIL rr_first_latency got=%0d exp=1", n); end
         end else begin
            tests++; if (cyc - last !== 6) begin fails++; $display("FAIL rr_spacing[%0d] got=%0d exp=6", k, cyc - last); end
         end
         last = cyc;
         tests++; if (dly_ce !== exp_ce[k]) begin fails++; $display("FAIL rr_ce[%0d] got=%b exp=%b", k, dly_ce, exp_ce[k]); end
         tests++; if (dly_inc !== exp_inc[k]) begin fails++; $display("FAIL rr_inc[%0d] got=%b exp=%b", k, dly_inc, exp_inc[k]); end
         tests++; if (gnt !== exp_ce[k]) begin fails++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt, exp_ce[k]); end
         repeat (4) tick();
         tests++; if (ack !== exp_ce[k]) begin fails++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, ack, exp_ce[k]); end
         $display("[TB] rr grant %0d ce=%b inc=%b", k, dly_ce, dly_inc);
      end
      req = 4'b0000;
      repeat (2) tick();
      tests++; if ({ready, gnt} !== 5'b10000) begin fails++; $display("FAIL rr_idle got=%b exp=10000", {ready, gnt}); end
   endtask

   task automatic test_loss_in_settle();
      int n;
      logic [3:0] ack_seen;
      req_inc = 4'b0000;
      req = 4'b0100;
      wait_ce(20, n);
      tests++; if ({dly_ce, dly_inc} !== 8'b0100_0000) begin fails++; $display("FAIL loss_grant got=%b exp=01000000", {dly_ce, dly_inc}); end
      tick();
      rdy = 1'b0;
      ack_seen = 4'b0000;
      repeat (3) begin tick(); ack_seen |= ack; end
      tests++; if (ack_seen !== 4'b0000) begin fails++; $display("FAIL loss_no_ack got=%b exp=0000", ack_seen); end
      tests++; if ({gnt, ready, dlyctrl_rst} !== 6'b0000_01) begin fails++; $display("FAIL loss_outputs got=%b exp=000001", {gnt, ready, dlyctrl_rst}); end
      tests++; if (relock !== 8'd1) begin fails++; $display("FAIL loss_relock got=%0d exp=1", relock); end
      repeat (5) tick();
      rdy = 1'b1;
      wait_ce(100, n);
      tests++; if (dly_ce !== 4'b0100) begin fails++; $display("FAIL loss_regrant got=%b exp=0100", dly_ce); end
      repeat (4) tick();
      tests++; if (ack !== 4'b0100) begin fails++; $display("FAIL loss_regrant_ack got=%b exp=0100", ack); end
      req = 4'b0000;
      $display("[TB] test_loss_in_settle done");
   endtask

   task automatic test_req_with_loss();
      int n;
      logic [3:0] ce_seen;
      logic       rst_seen;
      tick();
      rdy = 1'b0;
      repeat (2) tick();
      req_inc = 4'b0010;
      req = 4'b0010;
      ce_seen = 4'b0000;
      rst_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         ce_seen |= dly_ce;
         rst_seen |= dlyctrl_rst;
      end
      rdy = 1'b1;
      n = 0;
      while ((ready !== 1'b1) && (n < 100)) begin
         tick();
         ce_seen |= dly_ce;
         n++;
      end
      tests++; if (ce_seen !== 4'b0000) begin fails++; $display("FAIL rwl_no_ce got=%b exp=0000", ce_seen); end
      tests++; if (rst_seen !== 1'b1) begin fails++; $display("FAIL rwl_relock_pulse got=%b exp=1", rst_seen); end
      tests++; if (relock !== 8'd2) begin fails++; $display("FAIL rwl_relock got=%0d exp=2", relock); end
      wait_ce(20, n);
      tests++; if ({dly_ce, dly_inc} !== 8'b0010_0010) begin fails++; $display("FAIL rwl_grant_after got=%b exp=00100010", {dly_ce, dly_inc}); end
      repeat (4) tick();
      req = 4'b0000;
      $display("[TB] test_req_with_loss done");
   endtask

   task automatic test_saturate();
      int n;
      int bad;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         n = 0;
         while ((ready !== 1'b1) && (n < 200)) begin tick(); n++; end
         if (n >= 200) bad++;
         rdy = 1'b0;
         n = 0;
         while ((dlyctrl_rst !== 1'b1) && (n < 20)) begin tick(); n++; end
         if (n >= 20) bad++;
         rdy = 1'b1;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL sat_loop_timeouts got=%0d exp=0", bad); end
      tests++; if (relock !== 8'd255) begin fails++; $display("FAIL sat_relock got=%0d exp=255", relock); end
      $display("[TB] test_saturate done relock=%0d", relock);
   endtask

   task automatic test_rst_in_wait();
      int n;
      n = 0;
      while ((ready !== 1'b1) && (n < 200)) begin tick(); n++; end
      rdy = 1'b0;
      n = 0;
      while ((dlyctrl_rst !== 1'b1) && (n < 20)) begin tick(); n++; end
      n = 0;
      while ((dlyctrl_rst !== 1'b0) && (n < 40)) begin tick(); n++; end
      repeat (5) tick();
      tests++; if ({dlyctrl_rst, relock} !== {1'b0, 8'd255}) begin
         fails++; $display("FAIL rw_before got=%b/%0d exp=0/255", dlyctrl_rst, relock);
      end
      rst = 1'b1;
      tick();
      tests++; if (relock !== 8'd0) begin fails++; $display("FAIL rw_relock_clear got=%0d exp=0", relock); end
      tests++; if ({dlyctrl_rst, ready} !== 2'b10) begin fails++; $display("FAIL rw_outputs got=%b exp=10", {dlyctrl_rst, ready}); end
      rst = 1'b0;
      $display("[TB] test_rst_in_wait done");
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_calibrate();
      test_round_robin();
      test_loss_in_settle();
      test_req_with_loss();
      test_saturate();
      test_rst_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
